reg_dump_tx: RTL

Debug-side reader for the register bank's debug read port. On a start pulse it walks register addresses 0..REG_SIZE-1 and reads each register through the unit-debug address/data pair. It splits each word into bytes and hands them one at a time to the UART transmitter over a start/done handshake. It sits inside the debug unit, between the ID stage's debug port and the UART TX.

---
 rtl/reg_dump_tx.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/reg_dump_tx.sv
// reg_dump_tx: walks the register bank debug port and streams each register
// MSB-byte-first to a UART TX. Optional trailing XOR byte: REG_DUMP_CHECKSUM_EN.
module reg_dump_tx #(
    parameter int BITS_SIZE = 32,
    parameter int BITS_REGS = 5,
    parameter int REG_SIZE  = 32,
    parameter int BYTE_SIZE = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    output logic [BITS_REGS-1:0] o_addr_reg_unitdebug,
    input  logic [BITS_SIZE-1:0] i_data_reg_unitdebug,
    output logic [BYTE_SIZE-1:0] o_tx_data,
    output logic                 o_tx_start,
    input  logic                 i_tx_done,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int NBYTES = BITS_SIZE / BYTE_SIZE;
    localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [CW-1:0]        LAST_BYTE = CW'(NBYTES - 1);
    localparam logic [BITS_REGS-1:0] LAST_REG  = BITS_REGS'(REG_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT,
`ifdef REG_DUMP_CHECKSUM_EN
        S_CHK,
        S_CHK_WAIT,
`endif
        S_DONE
    } state_t;

    state_t               r_state;
    logic [BITS_REGS-1:0] r_addr;
    logic [CW-1:0]        r_cnt;
    logic [BITS_SIZE-1:0] r_shreg;
    logic [BYTE_SIZE-1:0] r_tx_data;
    logic                 r_tx_start;
    logic                 r_busy;
    logic                 r_done;

    logic [BITS_SIZE-1:0] w_shifted;
    logic [BYTE_SIZE-1:0] w_next_byte;
    logic [BYTE_SIZE-1:0] w_load_byte;

    // The byte after the current one is the top of the shifted word.
    assign w_shifted   = r_shreg << BYTE_SIZE;
    assign w_next_byte = w_shifted[BITS_SIZE-1 -: BYTE_SIZE];
    assign w_load_byte = i_data_reg_unitdebug[BITS_SIZE-1 -: BYTE_SIZE];

`ifdef REG_DUMP_CHECKSUM_EN
    logic [BYTE_SIZE-1:0] r_acc;
    logic                 w_send_load;
    logic                 w_send_next;

    assign w_send_load = (r_state == S_LOAD);
    assign w_send_next = (r_state == S_WAIT) && i_tx_done
                         && (r_cnt < LAST_BYTE);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_acc <= '0;
        end else if (r_state == S_IDLE) begin
            r_acc <= '0;
        end else if (w_send_load) begin
            r_acc <= r_acc ^ w_load_byte;
        end else if (w_send_next) begin
            r_acc <= r_acc ^ w_next_byte;
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_shreg    <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            r_done     <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_LOAD;
                        r_busy  <= 1'b1;
                        r_addr  <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_LOAD: begin
                    r_shreg    <= i_data_reg_unitdebug;
                    r_tx_data  <= w_load_byte;
                    r_tx_start <= 1'b1;
                    r_state    <= S_SEND;
                end
                S_SEND: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_tx_done) begin
                        r_shreg <= w_shifted;
                        if (r_cnt < LAST_BYTE) begin
                            r_cnt      <= r_cnt + 1'b1;
                            r_tx_data  <= w_next_byte;
                            r_tx_start <= 1'b1;
                            r_state    <= S_SEND;
                        end else if (r_addr < LAST_REG) begin
                            r_addr  <= r_addr + 1'b1;
                            r_cnt   <= '0;
                            r_state <= S_LOAD;
                        end else begin
`ifdef REG_DUMP_CHECKSUM_EN
                            r_tx_data  <= r_acc;
                            r_tx_start <= 1'b1;
                            r_state    <= S_CHK;
`else
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
`endif
                        end
                    end
                end
`ifdef REG_DUMP_CHECKSUM_EN
                S_CHK: begin
                    r_state <= S_CHK_WAIT;
                end
                S_CHK_WAIT: begin
                    if (i_tx_done) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_addr_reg_unitdebug = r_addr;
    assign o_tx_data            = r_tx_data;
    assign o_tx_start           = r_tx_start;
    assign o_busy               = r_busy;
    assign o_done               = r_done;

endmodule
